// File: rtl/debug_frame_builder.sv
// debug_frame_builder: queues debugger trigger events in a FIFO and frames them as byte packets.
// Optional macro DBG_TIMESTAMP_EN adds a 16-bit cycle timestamp to each entry and frame.
module debug_frame_builder #(
    parameter int          ADDR_W = 3,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic [7:0] data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       busy,
    output logic       drop
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef DBG_TIMESTAMP_EN
    localparam int EW = 32;
    localparam logic [2:0] LAST = 3'd6;
`else
    localparam int EW = 16;
    localparam logic [2:0] LAST = 3'd4;
`endif
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;
    logic [EW-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] count;
    logic [7:0] seq, drop_cnt, frame_drops;
    logic [EW-1:0] frame, entry;
    logic [2:0] idx;
    logic drop_q, full, push, dropped, pop, hs, done;
    logic [7:0] f_seq, f_data, chk, byte_sel;
    assign full    = count == (ADDR_W+1)'(DEPTH);
    assign push    = trigger && !full;
    assign dropped = trigger && full;
    assign pop     = state == IDLE && count != '0;
    assign hs      = state == SEND && tx_ready;
    assign done    = hs && idx == LAST;
    assign f_seq   = frame[EW-1 -: 8];
    assign f_data  = frame[7:0];
`ifdef DBG_TIMESTAMP_EN
    logic [15:0] ts;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ts <= '0;
        else ts <= ts + 16'd1;
    assign entry = {seq, ts, data};
    assign chk = MAGIC ^ f_seq ^ frame[23:16] ^ frame[15:8] ^ f_data ^ frame_drops;
    assign byte_sel = idx == 3'd0 ? MAGIC :
                      idx == 3'd1 ? f_seq :
                      idx == 3'd2 ? frame[23:16] :
                      idx == 3'd3 ? frame[15:8] :
                      idx == 3'd4 ? f_data :
                      idx == 3'd5 ? frame_drops : chk;
`else
    assign entry = {seq, data};
    assign chk = MAGIC ^ f_seq ^ f_data ^ frame_drops;
    assign byte_sel = idx == 3'd0 ? MAGIC :
                      idx == 3'd1 ? f_seq :
                      idx == 3'd2 ? f_data :
                      idx == 3'd3 ? frame_drops : chk;
`endif
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= entry;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            if (push) seq <= seq + 8'd1;
        end
    end
    // A drop coinciding with the snapshot is the first drop of the next window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= dropped;
            if (pop) drop_cnt <= {7'd0, dropped};
            else if (dropped && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame       <= '0;
            frame_drops <= '0;
            idx         <= '0;
        end else if (pop) begin
            frame       <= mem[rd_ptr];
            frame_drops <= drop_cnt;
            idx         <= '0;
        end else if (hs) begin
            idx <= idx + 3'd1;
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    always_comb
        state_nxt = state == IDLE ? (count != '0 ? SEND : IDLE) : (done ? IDLE : SEND);
    always_comb begin
        tx_valid = state == SEND;
        tx_data  = tx_valid ? byte_sel : 8'h00;
        tx_last  = tx_valid && idx == LAST;
        busy     = tx_valid || count != '0;
        drop     = drop_q;
    end
endmodule
